// File: rtl/control_seq.sv
// rtl/control_seq.sv - sequential control decoder for the 8-bit core
// Latches the instruction, owns phase/carry/ie, stalls on mem ack, handles irq entry.
module control_seq #(
    parameter int NSIG    = 8,
    parameter bit MEM_ACK = 1'b1,
    parameter bit HAS_IRQ = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      inst_i,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic            alu_carry_i,
    input  logic            mem_ack_i,
    input  logic            irq_i,
    output logic            M,
    output logic            S,
    output logic            J,
    output logic            LJ,
    output logic            CLI,
    output logic            LJR,
    output logic            MW,
    output logic            MC,
    output logic            RD,
    output logic            WR,
    output logic            Y,
    output logic            WA,
    output logic            ISP,
    output logic            WC,
    output logic [1:0]      RS,
    output logic [3:0]      ALU,
    output logic [NSIG-1:0] SIG,
    output logic            cycle_o,
    output logic            carry_o,
    output logic            ie_o,
    output logic            irq_take_o
);

    localparam int SW = $clog2(NSIG);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC0 = 2'd1,
        ST_EXEC1 = 2'd2,
        ST_IRQ   = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      ir;
    logic            carry_q;
    logic            ie_q;

    logic            c;
    logic            m_raw;
    logic            j_raw;
    logic            lj_raw;
    logic            cli_raw;
    logic            ljr_raw;
    logic            mw_raw;
    logic            mc_raw;
    logic            rd_raw;
    logic            wr_raw;
    logic            alu_path;
    logic            wa_raw;
    logic            isp_raw;
    logic            wc_raw;
    logic            sig_hit;
    logic [NSIG-1:0] sig_vec;

    logic            in_exec;
    logic            complete;
    logic            accept;

    // Raw decode from the latched instruction, phase and carry register only.
    always_comb begin
        c        = (state_q == ST_EXEC1);
        m_raw    = ir[7] & ~ir[6] & c;
        j_raw    = ir[7] & ir[6] & ir[5] & c & ~(carry_q & ir[4]);
        lj_raw   = ~ir[7] & ~ir[6] & ~ir[5] & ir[4] & ~ir[3];
        cli_raw  = lj_raw & ir[1];
        ljr_raw  = lj_raw & ir[2];
        mw_raw   = m_raw & ir[5];
        mc_raw   = ir[7] & ~c;
        rd_raw   = ~ir[7] & ~ir[6] & ~ir[5] & ~ir[4] & ir[2];
        wr_raw   = ~ir[7] & ~ir[6] & ~ir[5] & ~ir[4] & ir[3];
        alu_path = (ir[6] & ~ir[7]) | (c & ir[6] & ir[5]);
        wa_raw   = (m_raw & ~ir[5]) | (alu_path & ~(ir[4] & ~ir[3]));
        isp_raw  = ~ir[7] & ~ir[6] & ir[5];
        wc_raw   = (alu_path | isp_raw) & ir[4];
        sig_hit  = ~ir[7] & ~ir[6] & ~ir[5] & ir[4] & ir[3];
        sig_vec  = '0;
        sig_vec[ir[SW-1:0]] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        inst_ready_o = 1'b0;
        irq_take_o   = 1'b0;
        complete     = 1'b0;
        in_exec      = 1'b0;
        M   = 1'b0;
        S   = 1'b0;
        J   = 1'b0;
        LJ  = 1'b0;
        CLI = 1'b0;
        LJR = 1'b0;
        MW  = 1'b0;
        MC  = 1'b0;
        RD  = 1'b0;
        WR  = 1'b0;
        Y   = 1'b0;
        WA  = 1'b0;
        ISP = 1'b0;
        WC  = 1'b0;
        RS  = 2'b00;
        ALU = 4'h0;
        SIG = '0;
        case (state_q)
            ST_FETCH: begin
                // A pending interrupt wins over a valid instruction and withholds ready.
                if (HAS_IRQ && ie_q && irq_i) begin
                    state_d = ST_IRQ;
                end else begin
                    inst_ready_o = 1'b1;
                    if (inst_valid_i) state_d = ST_EXEC0;
                end
            end
            ST_EXEC0: begin
                in_exec  = 1'b1;
                complete = ~ir[7];
                state_d  = ir[7] ? ST_EXEC1 : ST_FETCH;
            end
            ST_EXEC1: begin
                in_exec  = 1'b1;
                complete = MEM_ACK ? mem_ack_i : 1'b1;
                if (complete) state_d = ST_FETCH;
            end
            ST_IRQ: begin
                irq_take_o = 1'b1;
                LJ         = 1'b1;
                CLI        = 1'b1;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        if (in_exec) begin
            M   = m_raw;
            S   = ir[4];
            J   = j_raw;
            LJ  = lj_raw;
            CLI = cli_raw;
            LJR = ljr_raw;
            MW  = mw_raw;
            MC  = mc_raw;
            RD  = rd_raw;
            WR  = wr_raw;
            Y   = ir[5];
            ISP = isp_raw;
            RS  = ir[1:0];
            ALU = ir[3:0];
            // Write-backs and signal pulses belong to the completing cycle only.
            WA  = wa_raw & complete;
            WC  = wc_raw & complete;
            SIG = (sig_hit & complete) ? sig_vec : '0;
        end
    end

    assign accept = inst_ready_o & inst_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            ir      <= 8'h00;
            carry_q <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) ir <= inst_i;
            if (complete && wc_raw) carry_q <= alu_carry_i;
            if ((state_q == ST_IRQ) || (complete && cli_raw)) begin
                ie_q <= 1'b0;
            end else if (complete && lj_raw && ir[0] && !ir[1]) begin
                ie_q <= 1'b1;
            end
        end
    end

    assign cycle_o = (state_q == ST_EXEC1);
    assign carry_o = carry_q;
    assign ie_o    = HAS_IRQ ? ie_q : 1'b0;

endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - directed self-checking bench for control_seq
module tb_control_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] inst_i;
    logic       inst_valid_i;
    logic       alu_carry_i;
    logic       mem_ack_i;
    logic       irq_i;

    logic       rdy, m, s, j, lj, cli, ljr, mw, mc, rd, wr, y, wa, isp, wc;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [7:0] sig;
    logic       cyc, car, ie, take;

    logic       rdy2, m2, s2, j2, lj2, cli2, ljr2, mw2, mc2, rd2, wr2, y2, wa2, isp2, wc2;
    logic [1:0] rs2;
    logic [3:0] alu2;
    logic [3:0] sig2;
    logic       cyc2, car2, ie2, take2;

    logic [13:0] ctl;
    logic [13:0] ctl2;
    logic [28:0] obs2;

    localparam logic [13:0] C_M   = 14'h2000;
    localparam logic [13:0] C_S   = 14'h1000;
    localparam logic [13:0] C_J   = 14'h0800;
    localparam logic [13:0] C_LJ  = 14'h0400;
    localparam logic [13:0] C_CLI = 14'h0200;
    localparam logic [13:0] C_MW  = 14'h0080;
    localparam logic [13:0] C_MC  = 14'h0040;
    localparam logic [13:0] C_Y   = 14'h0008;
    localparam logic [13:0] C_WA  = 14'h0004;
    localparam logic [13:0] C_WC  = 14'h0001;

    int total;
    int bad;

    control_seq #(.NSIG(8), .MEM_ACK(1'b1), .HAS_IRQ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .inst_ready_o(rdy), .alu_carry_i(alu_carry_i), .mem_ack_i(mem_ack_i), .irq_i(irq_i),
        .M(m), .S(s), .J(j), .LJ(lj), .CLI(cli), .LJR(ljr), .MW(mw), .MC(mc),
        .RD(rd), .WR(wr), .Y(y), .WA(wa), .ISP(isp), .WC(wc),
        .RS(rs), .ALU(alu), .SIG(sig), .cycle_o(cyc), .carry_o(car), .ie_o(ie),
        .irq_take_o(take)
    );

    control_seq #(.NSIG(4), .MEM_ACK(1'b1), .HAS_IRQ(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .inst_ready_o(rdy2), .alu_carry_i(alu_carry_i), .mem_ack_i(mem_ack_i), .irq_i(irq_i),
        .M(m2), .S(s2), .J(j2), .LJ(lj2), .CLI(cli2), .LJR(ljr2), .MW(mw2), .MC(mc2),
        .RD(rd2), .WR(wr2), .Y(y2), .WA(wa2), .ISP(isp2), .WC(wc2),
        .RS(rs2), .ALU(alu2), .SIG(sig2), .cycle_o(cyc2), .carry_o(car2), .ie_o(ie2),
        .irq_take_o(take2)
    );

    assign ctl  = {m, s, j, lj, cli, ljr, mw, mc, rd, wr, y, wa, isp, wc};
    assign ctl2 = {m2, s2, j2, lj2, cli2, ljr2, mw2, mc2, rd2, wr2, y2, wa2, isp2, wc2};
    assign obs2 = {ctl2, rs2, alu2, sig2, cyc2, car2, ie2, take2, rdy2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        inst_i = 8'h5C;
        inst_valid_i = 1'b1;
        alu_carry_i = 1'b0;
        mem_ack_i = 1'b0;
        irq_i = 1'b0;

        // reset with a valid instruction pending
        #1;
        chk("rst ctl", 32'(ctl), 32'h0);
        chk("rst ready", 32'(rdy), 32'h1);
        chk("rst flags", 32'({cyc, car, ie, take, sig}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        chk("5C ctl", 32'(ctl), 32'(C_S | C_WA | C_WC));
        chk("5C alu/rs", 32'({alu, rs}), 32'h30);
        chk("5C ready", 32'({rdy, cyc}), 32'h0);
        tick();
        chk("5C back fetch", 32'({rdy, ctl}), 32'h4000);
        chk("5C carry", 32'(car), 32'h0);

        // memory instruction with three stall cycles
        inst_i = 8'hA1;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        chk("A1 exec0 ctl", 32'(ctl), 32'(C_MC | C_Y));
        chk("A1 alu/rs", 32'({alu, rs}), 32'h5);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("A1 stall ctl", 32'(ctl), 32'(C_M | C_MW | C_Y));
            chk("A1 stall cycle", 32'({cyc, rdy}), 32'h2);
        end
        mem_ack_i = 1'b1;
        #1;
        chk("A1 ack ctl", 32'(ctl), 32'(C_M | C_MW | C_Y));
        tick();
        mem_ack_i = 1'b0;
        chk("A1 fetch", 32'({rdy, cyc}), 32'h2);

        // carry set by 50, jump suppressed by carry in F0
        inst_i = 8'h50;
        inst_valid_i = 1'b1;
        alu_carry_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        chk("50 ctl", 32'(ctl), 32'(C_S | C_WC));
        tick();
        chk("50 carry", 32'(car), 32'h1);
        inst_i = 8'hF0;
        inst_valid_i = 1'b1;
        alu_carry_i = 1'b0;
        tick();
        inst_valid_i = 1'b0;
        chk("F0 exec0 ctl", 32'(ctl), 32'(C_S | C_Y | C_MC));
        tick();
        chk("F0 c1 stall ctl", 32'(ctl), 32'(C_S | C_Y));
        mem_ack_i = 1'b1;
        #1;
        chk("F0 c1 ack ctl", 32'(ctl), 32'(C_S | C_Y | C_WC));
        tick();
        mem_ack_i = 1'b0;
        chk("F0 carry cleared", 32'(car), 32'h0);

        // same pair with carry clear: jump taken
        inst_i = 8'h50;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        tick();
        chk("50b carry", 32'(car), 32'h0);
        inst_i = 8'hF0;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        tick();
        chk("F0b stall ctl", 32'(ctl), 32'(C_S | C_Y | C_J));
        alu_carry_i = 1'b1;
        mem_ack_i = 1'b1;
        #1;
        chk("F0b ack ctl", 32'(ctl), 32'(C_S | C_Y | C_J | C_WC));
        tick();
        mem_ack_i = 1'b0;
        alu_carry_i = 1'b0;
        chk("F0b carry set", 32'(car), 32'h1);

        // signal pulse, both bus widths
        inst_i = 8'h1D;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        chk("1D sig8", 32'(sig), 32'h20);
        chk("1D ctl", 32'(ctl), 32'(C_S));
        chk("1D nsig4 outputs", 32'(obs2), 32'({C_S, 2'b01, 4'hD, 4'b0010, 5'b01000}));
        tick();
        chk("1D sig8 off", 32'(sig), 32'h0);
        chk("1D sig4 off", 32'(sig2), 32'h0);

        // set ie, then interrupt beats a valid instruction
        inst_i = 8'h11;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        chk("11 ctl", 32'(ctl), 32'(C_S | C_LJ));
        chk("11 ie before", 32'(ie), 32'h0);
        tick();
        chk("11 ie set", 32'(ie), 32'h1);
        irq_i = 1'b1;
        inst_i = 8'h40;
        inst_valid_i = 1'b1;
        #1;
        chk("irq ready low", 32'(rdy), 32'h0);
        tick();
        chk("irq take", 32'({take, rdy, ie}), 32'h5);
        chk("irq ctl", 32'(ctl), 32'(C_LJ | C_CLI));
        tick();
        chk("irq after", 32'({take, rdy, ie}), 32'h2);
        tick();
        inst_valid_i = 1'b0;
        irq_i = 1'b0;
        chk("40 ctl", 32'(ctl), 32'(C_WA));
        chk("40 alu/rs", 32'({alu, rs}), 32'h0);
        tick();

        // CLI instruction with i0 set still clears ie
        inst_i = 8'h11;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        tick();
        chk("11b ie set", 32'(ie), 32'h1);
        inst_i = 8'h13;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        chk("13 ctl", 32'(ctl), 32'(C_S | C_LJ | C_CLI));
        tick();
        chk("13 ie clear", 32'(ie), 32'h0);

        // reset asynchronously during a memory stall
        inst_i = 8'h11;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        tick();
        chk("pre-rst flags", 32'({car, ie}), 32'h3);
        inst_i = 8'hB0;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        chk("B0 exec0 ctl", 32'(ctl), 32'(C_S | C_Y | C_MC));
        tick();
        chk("B0 stall ctl", 32'(ctl), 32'(C_M | C_MW | C_S | C_Y));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst ctl", 32'(ctl), 32'h0);
        chk("async rst state", 32'({rdy, cyc, take, sig}), 32'h400);
        chk("async rst flags", 32'({car, ie}), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst fetch", 32'({rdy, cyc, ctl}), 32'h8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
